// File: rtl/serial_subtractor_pkg.sv
// Shared FSM encodings for the bit-serial arithmetic blocks (adder, subtractor, multiplier).
package serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor: d = a - b - c, e = borrow out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic e
);

    assign d = a ^ b ^ c;
    assign e = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, around one full_subtractor cell.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_res_sr;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow_q;
    logic             r_borrow_out;
    logic             r_busy;
    logic             r_done;
    logic [CNT_W-1:0] r_cnt;
    logic             w_d;
    logic             w_e;
    logic             w_last;

    full_subtractor u_cell (
        .a (r_a_sr[0]),
        .b (r_b_sr[0]),
        .c (r_borrow_q),
        .d (w_d),
        .e (w_e)
    );

    assign w_last = (r_cnt == CNT_W'(WIDTH - 1));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // busy/done are flopped from the next state so every output comes straight from a register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sr       <= '0;
            r_b_sr       <= '0;
            r_res_sr     <= '0;
            r_diff       <= '0;
            r_borrow_q   <= 1'b0;
            r_borrow_out <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_busy <= (w_state_nxt == SHIFT);
            r_done <= (w_state_nxt == DONE);
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr     <= a_in;
                        r_b_sr     <= b_in;
                        r_res_sr   <= '0;
                        r_borrow_q <= 1'b0;
                        r_cnt      <= '0;
                    end
                end
                SHIFT: begin
                    r_res_sr   <= {w_d, r_res_sr[WIDTH-1:1]};
                    r_a_sr     <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr     <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_borrow_q <= w_e;
                    r_cnt      <= r_cnt + 1'b1;
                    if (w_last) begin
                        r_diff       <= {w_d, r_res_sr[WIDTH-1:1]};
                        r_borrow_out <= w_e;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign diff       = r_diff;
    assign borrow_out = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: cycle model of a-b plus directed literal checks.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a_in = '0;
    logic [W-1:0] b_in = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;

    int n_cmp = 0;
    int n_err = 0;
    int n_done = 0;
    int cyc_n = 0;

    always #5 clk = ~clk;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: m_t counts cycles since an accepted start (0 = idle); result lands at W+1.
    int           m_t = 0;
    bit           m_valid = 0;
    logic [W-1:0] m_a = '0;
    logic [W-1:0] m_b = '0;
    logic [W-1:0] m_diff = '0;
    logic         m_bo = 1'b0;

    always @(posedge clk) begin
        cyc_n++;
        m_valid = 1;
        if (rst) begin
            m_t = 0;
            m_diff = '0;
            m_bo = 1'b0;
        end else if (m_t == 0) begin
            if (start) begin
                m_t = 1;
                m_a = a_in;
                m_b = b_in;
            end
        end else if (m_t < W + 1) begin
            m_t++;
            if (m_t == W + 1) begin
                m_diff = m_a - m_b;
                m_bo   = (m_a < m_b);
            end
        end else begin
            m_t = 0;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("busy", busy, (m_t >= 1 && m_t <= W));
            chk("done", done, (m_t == W + 1));
            chk("diff", diff, m_diff);
            chk("borrow_out", borrow_out, m_bo);
        end
        if (done) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input string nm,
                          input logic [W-1:0] ed, input logic eb);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W + 4 && !done; k++) tick();
        chk({nm, "_done"}, done, 1'b1);
        chk({nm, "_diff"}, diff, ed);
        chk({nm, "_borrow"}, borrow_out, eb);
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           d0;
        int           prev;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        rst = 1'b1;
        tick();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_diff", diff, 8'h00);
        chk("rst_borrow", borrow_out, 1'b0);
        rst = 1'b0;
        tick();

        run_op(8'h5A, 8'h23, "5A_23", 8'h37, 1'b0);
        run_op(8'h00, 8'h01, "00_01", 8'hFF, 1'b1);
        run_op(8'hFF, 8'hFF, "FF_FF", 8'h00, 1'b0);
        run_op(8'h80, 8'h7F, "80_7F", 8'h01, 1'b0);

        // Second start during SHIFT must be dropped.
        d0 = n_done;
        a_in = 8'h10; b_in = 8'h05; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        a_in = 8'hAA; b_in = 8'h01; start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < W + 4 && !done; k++) tick();
        chk("ign_diff", diff, 8'h0B);
        chk("ign_borrow", borrow_out, 1'b0);
        for (int k = 0; k < 15; k++) tick();
        chk("ign_done_count", n_done - d0, 1);

        // Reset in cycle 5 abandons the operation.
        a_in = 8'h33; b_in = 8'h11; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_diff", diff, 8'h00);
        chk("abort_borrow", borrow_out, 1'b0);
        d0 = n_done;
        for (int k = 0; k < 14; k++) tick();
        chk("abort_no_done", n_done - d0, 0);
        run_op(8'hC3, 8'h3C, "C3_3C", 8'h87, 1'b0);

        // Start held high: one result every W+2 cycles.
        a_in = 8'h9C; b_in = 8'hA7; start = 1'b1;
        prev = -1;
        for (int k = 0; k < 45; k++) begin
            tick();
            if (done) begin
                chk("held_diff", diff, 8'hF5);
                if (prev >= 0) chk("held_period", cyc_n - prev, W + 2);
                prev = cyc_n;
            end
        end
        start = 1'b0;
        for (int k = 0; k < W + 4; k++) tick();

        for (int n = 0; n < 1000; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, "rand", ra - rb, (ra < rb));
            for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
